// File: rtl/ram_pkg.sv
// ram_pkg: definitions shared by the DRAM controller and its timer.
//   ramState_t    - controller state (7 states, 3-bit encoding)
//   TIMER_W       - width of the shared precharge/RAS-low timer
//   TRP_DEF       - default precharge length in cycles (nRAS high)
//   TRAS_REF_DEF  - default nRAS-low length during refresh, in cycles
//   timerLoadVal  - converts a cycle count into the value loaded into the
//                   timer (the state is left on the edge after the timer
//                   reads zero, so n cycles load n-1)
package ram_pkg;

  localparam int TIMER_W      = 3;
  localparam int TRP_DEF      = 2;
  localparam int TRAS_REF_DEF = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_RAS = 3'd1,
    ACC_CAS = 3'd2,
    HOLD    = 3'd3,
    REF_CAS = 3'd4,
    REF_RAS = 3'd5,
    PRE     = 3'd6
  } ramState_t;

  function automatic logic [TIMER_W-1:0] timerLoadVal(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ram_timer.sv
// ram_timer: loadable down counter with a zero flag. Shared by the refresh
// RAS-low phase and the precharge phase of ram_ctl.
// Ports:
//   FCLK    - system clock, rising edge
//   nRST    - synchronous active-low reset, clears the count
//   load    - load loadVal this edge (takes priority over dec)
//   loadVal - value to load
//   dec     - count down by one this edge; holds at zero, never wraps
//   zero    - count is zero
module ram_timer
  import ram_pkg::*;
(
  input  logic               FCLK,
  input  logic               nRST,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadVal,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge FCLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ram_ctl.sv
// ram_ctl: DRAM controller serving 68HC000 bus cycles for the FSB block and
// arbitrating CAS-before-RAS refresh against CPU accesses.
// Ports:
//   FCLK        - system clock, all state changes on the rising edge
//   nRST        - synchronous active-low reset
//   ASActive    - AS currently asserted (from FSB)
//   ASInactive  - AS negated and settled (from FSB)
//   RAMCS       - address decodes to DRAM
//   nUDS, nLDS  - CPU upper/lower data strobes
//   nWE         - CPU R/W (0 = write)
//   RefReq      - refresh owed this period (from FSB)
//   RefUrgent   - refresh overdue, preempts a pending CPU access
//   RefAck      - one-cycle pulse when a refresh has been performed
//   RAMReady    - DRAM data valid / write accepted (to FSB Ready)
//   nRAS        - DRAM row strobe
//   nUCAS       - DRAM column strobe, upper byte
//   nLCAS       - DRAM column strobe, lower byte
//   nRAMWE      - DRAM write enable
//   RASEL       - address mux select: 0 = row, 1 = column
//   dbgState    - current controller state
//
// Handshake: a CPU cycle is requested by ASActive & RAMCS seen in IDLE.
// RAMReady rises once the column strobes are driven and stays high until
// the CPU negates AS (ASInactive); the controller then precharges for TRP
// cycles before it accepts the next request or a refresh. A refresh request
// (RefReq/RefUrgent) is acknowledged by a single RefAck pulse.
module ram_ctl
  import ram_pkg::*;
#(
  parameter int TRP      = TRP_DEF,
  parameter int TRAS_REF = TRAS_REF_DEF
) (
  input  logic      FCLK,
  input  logic      nRST,
  input  logic      ASActive,
  input  logic      ASInactive,
  input  logic      RAMCS,
  input  logic      nUDS,
  input  logic      nLDS,
  input  logic      nWE,
  input  logic      RefReq,
  input  logic      RefUrgent,
  output logic      RefAck,
  output logic      RAMReady,
  output logic      nRAS,
  output logic      nUCAS,
  output logic      nLCAS,
  output logic      nRAMWE,
  output logic      RASEL,
  output ramState_t dbgState
);

  localparam logic [TIMER_W-1:0] TRP_LOAD  = timerLoadVal(TRP);
  localparam logic [TIMER_W-1:0] TRAS_LOAD = timerLoadVal(TRAS_REF);

  ramState_t          state;
  logic               tmrLoad;
  logic [TIMER_W-1:0] tmrVal;
  logic               tmrDec;
  logic               tmrZero;
  logic               dsAny;

  assign dsAny    = ~nUDS | ~nLDS;
  assign dbgState = state;

  // Timer control mirrors the transitions below: TRAS_REF is loaded as the
  // refresh enters REF_RAS, TRP whenever a state is about to enter PRE.
  always_comb begin
    tmrLoad = 1'b0;
    tmrVal  = '0;
    tmrDec  = 1'b0;
    unique case (state)
      REF_CAS: begin
        tmrLoad = 1'b1;
        tmrVal  = TRAS_LOAD;
      end
      REF_RAS: begin
        if (tmrZero) begin
          tmrLoad = 1'b1;
          tmrVal  = TRP_LOAD;
        end else begin
          tmrDec = 1'b1;
        end
      end
      ACC_RAS: begin
        if (!dsAny && ASInactive) begin
          tmrLoad = 1'b1;
          tmrVal  = TRP_LOAD;
        end
      end
      HOLD: begin
        if (ASInactive) begin
          tmrLoad = 1'b1;
          tmrVal  = TRP_LOAD;
        end
      end
      PRE: begin
        tmrDec = 1'b1;
      end
      default: begin
        tmrLoad = 1'b0;
      end
    endcase
  end

  ram_timer uTimer (
    .FCLK    (FCLK),
    .nRST    (nRST),
    .load    (tmrLoad),
    .loadVal (tmrVal),
    .dec     (tmrDec),
    .zero    (tmrZero)
  );

  always_ff @(posedge FCLK) begin
    if (!nRST) begin
      state    <= IDLE;
      nRAS     <= 1'b1;
      nUCAS    <= 1'b1;
      nLCAS    <= 1'b1;
      nRAMWE   <= 1'b1;
      RASEL    <= 1'b0;
      RAMReady <= 1'b0;
      RefAck   <= 1'b0;
    end else begin
      RefAck <= 1'b0;
      unique case (state)
        IDLE: begin
          // An overdue refresh beats a CPU cycle; an owed one only runs
          // while the bus is quiet.
          if (RefUrgent) begin
            state <= REF_CAS;
            nUCAS <= 1'b0;
            nLCAS <= 1'b0;
          end else if (ASActive && RAMCS) begin
            state  <= ACC_RAS;
            nRAS   <= 1'b0;
            nRAMWE <= nWE;
          end else if (RefReq && !ASActive) begin
            state <= REF_CAS;
            nUCAS <= 1'b0;
            nLCAS <= 1'b0;
          end
        end

        ACC_RAS: begin
          // Row has been latched by now, so switch the mux to the column.
          RASEL  <= 1'b1;
          nRAMWE <= nWE;
          if (dsAny) begin
            state    <= ACC_CAS;
            nUCAS    <= nUDS;
            nLCAS    <= nLDS;
            RAMReady <= RAMCS;
          end else if (ASInactive) begin
            // Aborted cycle: no data strobe ever arrived.
            state    <= PRE;
            nRAS     <= 1'b1;
            nRAMWE   <= 1'b1;
            RASEL    <= 1'b0;
          end
        end

        ACC_CAS: begin
          state <= HOLD;
        end

        HOLD: begin
          if (ASInactive) begin
            state    <= PRE;
            nRAS     <= 1'b1;
            nUCAS    <= 1'b1;
            nLCAS    <= 1'b1;
            nRAMWE   <= 1'b1;
            RASEL    <= 1'b0;
            RAMReady <= 1'b0;
          end
        end

        REF_CAS: begin
          // CAS already low for one cycle; RAS now falls (CAS-before-RAS).
          state  <= REF_RAS;
          nRAS   <= 1'b0;
          RefAck <= 1'b1;
        end

        REF_RAS: begin
          if (tmrZero) begin
            state <= PRE;
            nRAS  <= 1'b1;
            nUCAS <= 1'b1;
            nLCAS <= 1'b1;
          end
        end

        PRE: begin
          if (tmrZero) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_ctl.md
Name: ram_ctl

Overview:
- DRAM controller that serves bus cycles for the 68HC000 front-side bus (FSB) block.
- Consumes the FSB's AS detection (ASActive, ASInactive) and refresh request (RefReq, RefUrgent).
- Returns RAMReady and RefAck to the FSB; RAMReady feeds the FSB Ready input whenever RAM is selected.
- Generates RAS, byte-lane CAS, WE and the row/column address-mux select, and arbitrates CAS-before-RAS refresh against CPU accesses.

Parameters:
TRP, 2, precharge cycles (nRAS high) after any access or refresh; legal 1..7
TRAS_REF, 3, cycles nRAS stays low during refresh; legal 1..7

Ports:
FCLK  in  1  system clock; all state changes on rising edge
nRST  in  1  synchronous active-low reset
ASActive  in  1  AS currently asserted (from FSB)
ASInactive  in  1  AS negated and settled (from FSB)
RAMCS  in  1  address decodes to DRAM
nUDS  in  1  CPU upper data strobe
nLDS  in  1  CPU lower data strobe
nWE  in  1  CPU R/W (0 = write)
RefReq  in  1  refresh owed this period (from FSB)
RefUrgent  in  1  refresh overdue; must preempt CPU (from FSB)
RefAck  out  1  one-cycle pulse, refresh performed (to FSB)
RAMReady  out  1  DRAM data valid/accepted (to FSB Ready)
nRAS  out  1  DRAM row strobe
nUCAS  out  1  DRAM column strobe, upper byte
nLCAS  out  1  DRAM column strobe, lower byte
nRAMWE  out  1  DRAM write enable
RASEL  out  1  address mux: 0 = row, 1 = column

Behaviour:
- All outputs are registered. Reset (nRST=0 at an edge) gives state IDLE, timer 0, nRAS=nUCAS=nLCAS=nRAMWE=1, RASEL=0, RAMReady=0, RefAck=0.
- Reset asserted mid-access or mid-refresh: all strobes negate on that same edge; no RefAck is issued.
- States: IDLE, ACC_RAS, ACC_CAS, HOLD, REF_CAS, REF_RAS, PRE.
- IDLE arbitration priority, highest first:
  - RefUrgent -> REF_CAS.
  - ASActive & RAMCS -> ACC_RAS.
  - RefReq & ~ASActive -> REF_CAS.
  - Otherwise stay in IDLE.
- ASActive & RAMCS & RefUrgent in the same cycle: refresh wins. The access is served after PRE returns to IDLE; RAMReady stays 0 meanwhile.
- ACC_RAS:
  - nRAS=0 on entry; RASEL=1 on the next edge; nRAMWE=nWE.
  - Advance to ACC_CAS when (~nUDS | ~nLDS).
  - If ASInactive occurs first (aborted cycle), go to PRE.
- ACC_CAS:
  - nUCAS=nUDS and nLCAS=nLDS, registered.
  - RAMReady=1 from the entry edge; go to HOLD.
  - Read latency: AS sampled active in IDLE -> RAMReady high 2 edges later, minimum (ACC_RAS, ACC_CAS).
- HOLD:
  - Strobes and RAMReady hold.
  - On ASInactive go to PRE; on that edge nRAS, nUCAS, nLCAS, nRAMWE go to 1 and RASEL, RAMReady go to 0.
- REF_CAS: nUCAS=nLCAS=0 for 1 cycle, nRAS=1; go to REF_RAS.
- REF_RAS:
  - nRAS=0 for TRAS_REF cycles, CAS held low.
  - RefAck=1 for exactly the first cycle.
  - Then go to PRE with all strobes negated.
- PRE:
  - Timer loads TRP-1 on entry; stay until the timer reaches 0, then go to IDLE.
  - Requests arriving during PRE are evaluated in IDLE; a back-to-back access waits.
- RAMReady is never asserted while RAMCS=0. AS negating during refresh has no effect on refresh timing.
- Timer is 3-bit, down-counting, saturates at 0; no wrap.
- Invariants:
  - CAS never falls while nRAS=1 during an access.
  - nRAS high is never shorter than TRP cycles between RAS low periods.

Decomposition:
- Shared package ram_pkg: state enum (7 states, 3-bit encoding), default TRP/TRAS_REF constants, timer width (3).
- One sub-module, ram_timer: loadable 3-bit down counter with a zero flag. It is used for both PRE and REF_RAS.
- The FSM and output registers stay in ram_ctl.

Test Plan:
1. Read: reset, then ASActive=1, RAMCS=1, nUDS=nLDS=0, nWE=1.
   - Expected: nRAS low edge 1, RASEL=1 edge 2, nUCAS=nLCAS=0 and RAMReady=1 edge 2.
   - ASInactive -> all negated next edge; IDLE after TRP=2 more edges.
2. Byte write: nWE=0, nLDS=0, nUDS=1.
   - Expected: nRAMWE=0, nLCAS=0, nUCAS stays 1 for the whole cycle.
3. Collision: RefUrgent=1 together with ASActive & RAMCS in IDLE.
   - Expected: REF_CAS first, RefAck single pulse, nRAS low 3 cycles, PRE 2.
   - Then the access proceeds; RAMReady=0 throughout the refresh.
4. Idle refresh: RefReq=1, ASActive=0.
   - Expected: refresh starts next edge, CAS falls one cycle before RAS, RefAck exactly 1 cycle.
5. Abort: ASActive with DS never asserted, then ASInactive.
   - Expected: ACC_RAS -> PRE, CAS never asserted, RAMReady never 1.
6. Reset mid-access: nRST=0 in HOLD.
   - Expected: all strobes 1 and RAMReady=0 on the same edge; IDLE after reset release.
